// File: rtl/sprite_scaler.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_scaler
//  Description : Streams one integer-upscaled sprite frame from a sprite ROM.
//                Each source pixel is fetched once per output row repetition
//                and then replicated SCALE times horizontally. Output rows
//                are produced by rewinding to the same source row SCALE
//                times. Pixels leave through a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_out     in   1           clock, rising edge
//    rst         in   1           synchronous reset, active low
//    start       in   1           request one frame (accepted only when idle)
//    img_sel     in   3           sprite index, sampled on accepted start
//    rom_addr    out  ADDR_W      sprite ROM read address
//    rom_en      out  1           ROM read enable (data one cycle later)
//    rom_data    in   PIXEL_SIZE  ROM read data
//    pixel_data  out  PIXEL_SIZE  scaled output pixel
//    pixel_valid out  1           pixel_data holds a pixel
//    pixel_ready in   1           downstream accepts the pixel
//    busy        out  1           frame in progress
//    frame_done  out  1           one-cycle pulse after last pixel accepted
// ============================================================================
module sprite_scaler #(
   parameter int                    SRC_W      = 80,
   parameter int                    SRC_H      = 80,
   parameter int                    SCALE      = 3,
   parameter int                    PIXEL_SIZE = 16,
   parameter int                    IMAGES     = 5,
   parameter logic [PIXEL_SIZE-1:0] FILL_COLOR = 'h001F,
   parameter int                    ADDR_W     = $clog2(IMAGES*SRC_W*SRC_H)
) (
   input  logic                  clk_out,
   input  logic                  rst,
   input  logic                  start,
   input  logic [2:0]            img_sel,
   output logic [ADDR_W-1:0]     rom_addr,
   output logic                  rom_en,
   input  logic [PIXEL_SIZE-1:0] rom_data,
   output logic [PIXEL_SIZE-1:0] pixel_data,
   output logic                  pixel_valid,
   input  logic                  pixel_ready,
   output logic                  busy,
   output logic                  frame_done
);

   // -------------------------------------------------------------------------
   // Derived constants
   // -------------------------------------------------------------------------
   localparam int FRAME_PIX = SRC_W * SRC_H;
   localparam int SX_W      = (SRC_W > 1) ? $clog2(SRC_W) : 1;
   localparam int SY_W      = (SRC_H > 1) ? $clog2(SRC_H) : 1;
   localparam int REP_W     = (SCALE > 1) ? $clog2(SCALE) : 1;

   localparam logic [SX_W-1:0]   SX_LAST  = SX_W'(SRC_W - 1);
   localparam logic [SY_W-1:0]   SY_LAST  = SY_W'(SRC_H - 1);
   localparam logic [REP_W-1:0]  REP_LAST = REP_W'(SCALE - 1);
   localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(SRC_W);

   // -------------------------------------------------------------------------
   // State encoding
   // -------------------------------------------------------------------------
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ADDR = 3'd1,
      S_WAIT = 3'd2,
      S_OUT  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t                  state_q,    state_d;
   logic [SX_W-1:0]         sx_q,       sx_d;
   logic [SY_W-1:0]         sy_q,       sy_d;
   logic [REP_W-1:0]        rep_x_q,    rep_x_d;
   logic [REP_W-1:0]        rep_y_q,    rep_y_d;
   logic [ADDR_W-1:0]       row_base_q, row_base_d;
   logic                    fill_q,     fill_d;
   logic [PIXEL_SIZE-1:0]   pixel_q,    pixel_d;

   // Image base is formed once per frame when the start is accepted; the
   // per-pixel address path is only row_base + sx.
   logic [ADDR_W-1:0]       img_base;
   logic                    img_out_of_range;
   logic                    last_rep_x;
   logic                    last_sx;
   logic                    last_rep_y;
   logic                    last_sy;

   assign img_base         = ADDR_W'(int'(img_sel) * FRAME_PIX);
   assign img_out_of_range = (int'(img_sel) >= IMAGES);
   assign last_rep_x       = (rep_x_q == REP_LAST);
   assign last_sx          = (sx_q    == SX_LAST);
   assign last_rep_y       = (rep_y_q == REP_LAST);
   assign last_sy          = (sy_q    == SY_LAST);

   // -------------------------------------------------------------------------
   // State and datapath registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk_out) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         sx_q       <= '0;
         sy_q       <= '0;
         rep_x_q    <= '0;
         rep_y_q    <= '0;
         row_base_q <= '0;
         fill_q     <= 1'b0;
         pixel_q    <= '0;
      end else begin
         state_q    <= state_d;
         sx_q       <= sx_d;
         sy_q       <= sy_d;
         rep_x_q    <= rep_x_d;
         rep_y_q    <= rep_y_d;
         row_base_q <= row_base_d;
         fill_q     <= fill_d;
         pixel_q    <= pixel_d;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic and outputs
   // -------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      sx_d       = sx_q;
      sy_d       = sy_q;
      rep_x_d    = rep_x_q;
      rep_y_d    = rep_y_q;
      row_base_d = row_base_q;
      fill_d     = fill_q;
      pixel_d    = pixel_q;

      rom_en      = 1'b0;
      rom_addr    = row_base_q + ADDR_W'(sx_q);
      pixel_valid = 1'b0;
      busy        = 1'b1;
      frame_done  = 1'b0;

      case (state_q)
         S_IDLE: begin
            busy = 1'b0;
            if (start) begin
               fill_d     = img_out_of_range;
               row_base_d = img_base;
               sx_d       = '0;
               sy_d       = '0;
               rep_x_d    = '0;
               rep_y_d    = '0;
               state_d    = S_ADDR;
            end
         end

         S_ADDR: begin
            // An out-of-range sprite walks the same sequence with the ROM
            // left idle so count, order and handshake stay identical.
            rom_en  = !fill_q;
            state_d = S_WAIT;
         end

         S_WAIT: begin
            pixel_d = fill_q ? FILL_COLOR : rom_data;
            state_d = S_OUT;
         end

         S_OUT: begin
            pixel_valid = 1'b1;
            if (pixel_ready) begin
               if (!last_rep_x) begin
                  // Horizontal replication: same pixel, no ROM access.
                  rep_x_d = rep_x_q + 1'b1;
               end else begin
                  rep_x_d = '0;
                  state_d = S_ADDR;
                  if (!last_sx) begin
                     sx_d = sx_q + 1'b1;
                  end else begin
                     sx_d = '0;
                     if (!last_rep_y) begin
                        // Repeat the same source row; row base is unchanged.
                        rep_y_d = rep_y_q + 1'b1;
                     end else begin
                        rep_y_d = '0;
                        if (last_sy) begin
                           state_d = S_DONE;
                        end else begin
                           sy_d       = sy_q + 1'b1;
                           row_base_d = row_base_q + ROW_STEP;
                        end
                     end
                  end
               end
            end
         end

         S_DONE: begin
            // Start is deliberately ignored here; only IDLE accepts it.
            frame_done = 1'b1;
            state_d    = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign pixel_data = pixel_q;

endmodule
`default_nettype wire
